// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO feeding registered ALU operands, with a
// result capture register presented over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no command in flight; pop the FIFO head when one is queued
// S_ISSUE | operands on alu_*; capture alu_y into res_* on this edge
// S_HOLD  | res_valid high; wait for res_ready, then pop next or idle
module alu_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_f,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_f,
  input  logic [63:0] alu_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_y,
  output logic [3:0]  res_f,
  output logic        res_zero,
  output logic        res_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [67:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_release;
  logic            w_nonempty;
  logic            w_div0;
  logic [67:0]     w_head;

  // r_in_ready keeps cmd_ready low through reset and releases it one edge later
  assign cmd_ready  = r_in_ready && (r_count != CW'(DEPTH));
  assign w_push     = cmd_valid && cmd_ready;
  // Pop decisions look at the count before any same-edge push
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_div0     = ((alu_f == 4'b0011) || (alu_f == 4'b0100)) && (alu_b == 32'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_nonempty) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  if (res_ready) w_state_nxt = w_nonempty ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM control strobes; res_valid is always high in S_HOLD
  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = w_nonempty;
      S_ISSUE: w_capture = 1'b1;
      S_HOLD: begin
        w_release = res_ready;
        w_pop     = res_ready && w_nonempty;
      end
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_f, cmd_b, cmd_a};
  end

  // FIFO pointers, occupancy and input-ready release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand registers load only on a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_f <= '0;
    end else if (w_pop) begin
      alu_a <= w_head[31:0];
      alu_b <= w_head[63:32];
      alu_f <= w_head[67:64];
    end
  end

  // Result capture; divide/modulo by zero overrides whatever the ALU drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_f     <= '0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
    end else if (w_capture) begin
      res_valid <= 1'b1;
      res_f     <= alu_f;
      if (w_div0) begin
        res_y    <= '0;
        res_zero <= 1'b1;
        res_err  <= 1'b1;
      end else begin
        res_y    <= alu_y;
        res_zero <= (alu_y == 64'd0);
        res_err  <= 1'b0;
      end
    end else if (w_release) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, vector table and scoreboard.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_f;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_f;
  logic [63:0] alu_y;
  logic        res_valid, res_ready;
  logic [63:0] res_y;
  logic [3:0]  res_f;
  logic        res_zero, res_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [63:0] y;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] y;
    logic [3:0]  f;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_issue_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_f(cmd_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_f(res_f), .res_zero(res_zero), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Reference ALU; div/mod by zero drive junk so the override is visible
  always_comb begin
    case (alu_f)
      4'b0000: alu_y = {32'd0, alu_a} + {32'd0, alu_b};
      4'b0001: alu_y = {32'd0, alu_a - alu_b};
      4'b0010: alu_y = {32'd0, alu_a} * {32'd0, alu_b};
      4'b0011: alu_y = (alu_b == 0) ? 64'hBAD0 : {32'd0, alu_a % alu_b};
      4'b0100: alu_y = (alu_b == 0) ? 64'hBAD1 : {32'd0, alu_a / alu_b};
      default: alu_y = {32'd0, alu_a ^ alu_b};
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every result handshake against the queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_y", res_y, e.y);
        chk("res_f", {60'd0, res_f}, {60'd0, e.f});
        chk("res_zero", {63'd0, res_zero}, {63'd0, e.zero});
        chk("res_err", {63'd0, res_err}, {63'd0, e.err});
      end
    end
  end

  function automatic exp_t mk(input logic [63:0] y, input logic [3:0] f,
                              input logic z, input logic e);
    exp_t r;
    r.y = y; r.f = f; r.zero = z; r.err = e;
    return r;
  endfunction

  task automatic send(input vec_t v);
    int  n = 0;
    bit  done = 0;
    cmd_a = v.a; cmd_b = v.b; cmd_f = v.f; cmd_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        sb.push_back(mk(v.y, v.f, v.zero, v.err));
        done = 1;
      end else begin
        @(posedge clk);
        n++;
        if (n > 200) begin
          chk("send_timeout", 64'd1, 64'd0);
          done = 1;
        end
      end
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[10];
  bit   rdy[4];
  bit   pat[8];
  bit   acc;
  bit   got4;

  initial begin
    vecs[0] = '{32'd5,          32'd3,       4'b0000, 64'd8,           1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd2,       4'b0010, 64'h1_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'd7,          32'd7,       4'b0001, 64'd0,           1'b1, 1'b0};
    vecs[3] = '{32'd100,        32'd0,       4'b0100, 64'd0,           1'b1, 1'b1};
    vecs[4] = '{32'd100,        32'd0,       4'b0011, 64'd0,           1'b1, 1'b1};
    vecs[5] = '{32'd100,        32'd7,       4'b0011, 64'd2,           1'b0, 1'b0};
    vecs[6] = '{32'd100,        32'd7,       4'b0100, 64'd14,          1'b0, 1'b0};
    vecs[7] = '{32'h0001_0000,  32'h0001_0000, 4'b0010, 64'h1_0000_0000, 1'b0, 1'b0};
    vecs[8] = '{32'd0,          32'd0,       4'b0000, 64'd0,           1'b1, 1'b0};
    vecs[9] = '{32'd0,          32'd0,       4'b0010, 64'd0,           1'b1, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_f = '0; res_ready = 1'b1;

    // Reset values
    #3;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_y", res_y, 64'd0);
    chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
    chk("rst_flags", {61'd0, res_zero, res_err, res_f != 0}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("cmd_ready_before_edge", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_edge", {63'd0, cmd_ready}, 64'd1);

    // Latency: accept at E0, operands after E1, result after E2
    cmd_a = 32'd5; cmd_b = 32'd3; cmd_f = 4'b0000; cmd_valid = 1'b1;
    @(posedge clk);
    sb.push_back(mk(64'd8, 4'b0000, 1'b0, 1'b0));
    #1 cmd_valid = 1'b0;
    chk("lat_e0_alu_a", {32'd0, alu_a}, 64'd0);
    @(posedge clk); #1;
    chk("lat_e1_alu_a", {32'd0, alu_a}, 64'd5);
    chk("lat_e1_alu_b", {32'd0, alu_b}, 64'd3);
    chk("lat_e1_res_valid", {63'd0, res_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_e2_res_valid", {63'd0, res_valid}, 64'd1);
    chk("lat_e2_res_y", res_y, 64'd8);
    drain();

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < 10; i++) send(vecs[i]);
    drain();

    // Backpressure: four back-to-back pushes with res_ready low
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cmd_a = 32'(i); cmd_b = 32'(i); cmd_f = 4'b0000; cmd_valid = 1'b1;
      @(negedge clk);
      rdy[i-1] = cmd_ready;
      @(posedge clk);
      if (rdy[i-1]) sb.push_back(mk(64'(2*i), 4'b0000, 1'b0, 1'b0));
      #1;
    end
    chk("bp_ready_pattern", {60'd0, rdy[0], rdy[1], rdy[2], rdy[3]}, 64'b1110);
    chk("bp_cmd_ready_full", {63'd0, cmd_ready}, 64'd0);
    got4 = !rdy[3];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {63'd0, res_valid}, 64'd1);
      chk("bp_hold_y", res_y, 64'd2);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = res_valid;
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      if (acc) begin
        sb.push_back(mk(64'd8, 4'b0000, 1'b0, 1'b0));
        got4 = 1'b1;
      end
      #1;
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("bp_cmd4_accepted", {63'd0, got4}, 64'd1);
    chk("bp_valid_pattern",
        {56'd0, pat[0], pat[1], pat[2], pat[3], pat[4], pat[5], pat[6], pat[7]},
        64'b10101010);
    drain();

    // Reset mid-operation with a result pending and two commands queued
    res_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cmd_a = 32'(10 * i); cmd_b = 32'(i); cmd_f = 4'b0000; cmd_valid = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("mid_res_valid", {63'd0, res_valid}, 64'd1);
    chk("mid_res_y", res_y, 64'd11);
    chk("mid_full", {63'd0, cmd_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_res_y", res_y, 64'd0);
    chk("mid_rst_alu", {28'd0, alu_f, alu_a}, 64'd0);
    chk("mid_rst_alu_b", {32'd0, alu_b}, 64'd0);
    chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mid_no_result", {63'd0, res_valid}, 64'd0);
    end

    // Stage still works after the mid-operation reset
    send(vecs[6]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-buffering issue and capture stage wrapped around the 32-bit combinational ALU. It accepts `(a, b, f)` commands over a valid/ready handshake and queues them in a small FIFO. It drives one command at a time onto registered ALU operand lines, then captures the 64-bit ALU result on the following edge with zero and divide-by-zero status. The result is presented downstream over a second valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 2: command FIFO depth; power of two, ≥2.

Ports:
- `clk`  in  1  one clock; all state updates on its rising edge.
- `rst_n`  in  1  reset is asynchronous and active-low.
- `cmd_valid`  in  1  upstream command valid.
- `cmd_ready`  out  1  high when the FIFO is not full.
- `cmd_a`  in  32  operand A.
- `cmd_b`  in  32  operand B.
- `cmd_f`  in  4  ALU opcode; same 16-code encoding as the ALU (0010 mul, 0011 mod, 0100 div, ...).
- `alu_a`  out  32  registered operand A to the ALU.
- `alu_b`  out  32  registered operand B to the ALU.
- `alu_f`  out  4  registered opcode to the ALU.
- `alu_y`  in  64  combinational ALU result.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accepts the result.
- `res_y`  out  64  captured result.
- `res_f`  out  4  opcode that produced `res_y`.
- `res_zero`  out  1  high when `res_y == 0`.
- `res_err`  out  1  div or mod issued with `b == 0`.

## Operation
- **FIFO:**
  - Push when `cmd_valid && cmd_ready`.
  - Pop only under FSM control.
  - Order is strictly preserved.
  - Occupancy counter runs 0..DEPTH; `cmd_ready = (count != DEPTH)`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM** (states IDLE, ISSUE, HOLD):
  - IDLE: if count>0, pop the FIFO head into `alu_a/b/f` and go to ISSUE. Otherwise stay.
  - ISSUE: capture results. `res_y <= alu_y`, `res_f <= alu_f`, `res_zero <= (alu_y == 0)`, `res_err <= 0`, `res_valid <= 1`, then go to HOLD.
  - ISSUE, divide-by-zero case: if `alu_f` is 0011 or 0100 and `alu_b == 0`, force `res_y = 0`, `res_zero = 1`, `res_err = 1` instead, ignoring `alu_y`.
  - HOLD: the result and `res_*` stay stable while `res_valid && !res_ready`.
  - HOLD, on handshake: if count>0, pop the next command into `alu_*` and go to ISSUE, with `res_valid <= 0`. Otherwise go to IDLE with `res_valid <= 0`.
- **Pop decision:** uses the count before the same-edge push. A command pushed into an empty FIFO is not popped on its push edge.
- **Operand registers:** `alu_*` change only on a pop edge and hold between pops.
- **Result width:** `res_y` is the full 64-bit `alu_y`, unmodified except in the divide-by-zero case.

## Timing
- **Reset (`rst_n = 0`, asynchronous):**
  - State goes to IDLE and the FIFO empties (count 0).
  - `cmd_ready = 0` while in reset, then 1 from the first cycle after deassertion.
  - `alu_a/b/f`, `res_y`, `res_f` = 0; `res_valid`, `res_zero`, `res_err` = 0.
- **Reset mid-operation:** discards the in-flight command and all queued commands. No result is emitted for them.
- **Latency:**
  - Command accepted at edge E0 into an empty, idle stage.
  - `alu_*` valid after E1.
  - `res_valid` high after E2, i.e. 2 cycles.
- **Throughput:** with `res_ready` held high and the FIFO non-empty, one result every 2 cycles. `res_valid` is low for exactly one cycle between results.
- **Combinational path:** the ALU path must settle within one `clk` period (`alu_*` register → ALU → `res_y` register).
- **Ready/valid independence:** `cmd_ready` does not depend combinationally on `res_ready`. `res_valid` does not depend on `res_ready`.

## Test plan
- **Single add:** a=5, b=3, f=0000 accepted at E0 → `alu_a=5` after E1; `res_valid=1`, `res_y=8`, `res_zero=0`, `res_err=0` after E2.
- **Wide multiply and zero flag:**
  - a=0xFFFFFFFF, b=2, f=0010 → `res_y=0x1_FFFF_FFFE`.
  - Then a=7, b=7, f=0001 → `res_y=0`, `res_zero=1`.
- **Divide-by-zero:**
  - a=100, b=0, f=0100 → `res_y=0`, `res_err=1`, `res_zero=1`.
  - a=100, b=0, f=0011 → same.
  - a=100, b=7, f=0011 → `res_y=2`, `res_err=0`.
- **Backpressure, DEPTH=2:**
  - `res_ready=0`; push commands 1+1, 2+2, 3+3, 4+4 back-to-back.
  - Expect `cmd_ready=0` after the third push and the fourth stalled.
  - `res_y` holds 2 while stalled.
  - Releasing `res_ready` yields 2, 4, 6, 8 in order, with one invalid cycle between each.
- **Reset mid-operation:**
  - With two queued commands and `res_valid=1`, assert `rst_n=0` for one cycle.
  - Expect all outputs at reset values immediately and no further `res_valid` without new commands.
